// File: rtl/md_pkg.sv
// md_buffer shared package
// Size codes, FSM states and width helpers.
package md_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_FULL = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2
  } md_state_t;

  function automatic int md_lanes(input int dw);
    return dw / 8;
  endfunction

  function automatic int md_ofs_w(input int dw);
    return $clog2(dw / 8);
  endfunction

  // b0 = offset bit 0, nz = offset non-zero
  function automatic logic md_misal(
    input logic [1:0] sz,
    input logic       b0,
    input logic       nz
  );
    return (sz == SZ_RSVD) ||
           ((sz == SZ_HALF) && b0) ||
           ((sz == SZ_FULL) && nz);
  endfunction

endpackage

// File: rtl/md_lane_align.sv
// md_buffer lane alignment
// Load extract/extend and store replicate/byte-enable.
module md_lane_align
  import md_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES  = DATA_W / 8,
  parameter int OFS_W  = $clog2(DATA_W / 8)
) (
  input  logic [1:0]        ld_size,
  input  logic              ld_uns,
  input  logic [OFS_W-1:0]  ld_ofs,
  input  logic [DATA_W-1:0] ld_rdata,
  output logic [DATA_W-1:0] ld_data,
  input  logic [1:0]        st_size,
  input  logic [OFS_W-1:0]  st_ofs,
  input  logic [DATA_W-1:0] st_src,
  output logic [DATA_W-1:0] st_data,
  output logic [LANES-1:0]  st_be
);

  logic [DATA_W-1:0] w_sh;
  logic              w_sx;

  // Load: shift addressed lane down, then extend
  always_comb begin
    w_sh    = ld_rdata >> {ld_ofs, 3'b000};
    w_sx    = 1'b0;
    ld_data = ld_rdata;
    unique case (ld_size)
      SZ_BYTE: begin
        w_sx    = ~ld_uns & w_sh[7];
        ld_data = {{(DATA_W-8){w_sx}}, w_sh[7:0]};
      end
      SZ_HALF: begin
        w_sx    = ~ld_uns & w_sh[15];
        ld_data = {{(DATA_W-16){w_sx}}, w_sh[15:0]};
      end
      default: ld_data = ld_rdata;
    endcase
  end

  // Store: replicate low bits to all lanes, enable addressed lanes
  always_comb begin
    st_data = '0;
    st_be   = '0;
    unique case (st_size)
      SZ_BYTE: begin
        st_data = {LANES{st_src[7:0]}};
        st_be   = LANES'(1) << st_ofs;
      end
      SZ_HALF: begin
        st_data = {(LANES/2){st_src[15:0]}};
        st_be   = LANES'(3) << st_ofs;
      end
      SZ_FULL: begin
        st_data = st_src;
        st_be   = '1;
      end
      default: begin
        st_data = '0;
        st_be   = '0;
      end
    endcase
  end

endmodule

// File: rtl/md_buffer.sv
// md_buffer: memory data register with own req/ack handshake.
// Define MDR_TIMEOUT_EN to abort waits after TIMEOUT_CYC cycles.
module md_buffer
  import md_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16,
  parameter int LANES       = md_lanes(DATA_W),
  parameter int OFS_W       = md_ofs_w(DATA_W)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              enable,
  input  logic [DATA_W-1:0] bus_data,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [OFS_W-1:0]  addr_lo,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [LANES-1:0]  mem_be,
  output logic [DATA_W-1:0] Q,
  output logic              busy,
  output logic              done,
  output logic              err
);

  md_state_t         r_state, w_state_nxt;
  logic [DATA_W-1:0] r_q, w_q_nxt;
  logic              r_rd, w_rd_nxt;
  logic              r_wr, w_wr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic [LANES-1:0]  r_be, w_be_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
  logic [1:0]        r_sz, w_sz_nxt;
  logic              r_uns, w_uns_nxt;
  logic [OFS_W-1:0]  r_ofs, w_ofs_nxt;
  logic [DATA_W-1:0] w_ld_data;
  logic [DATA_W-1:0] w_st_data;
  logic [LANES-1:0]  w_st_be;
  logic              w_misal;

`ifdef MDR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
`else
  if (TIMEOUT_CYC < 2) begin : g_to_unused
  end
`endif

  md_lane_align #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .OFS_W  (OFS_W)
  ) u_align (
    .ld_size  (r_sz),
    .ld_uns   (r_uns),
    .ld_ofs   (r_ofs),
    .ld_rdata (mem_rdata),
    .ld_data  (w_ld_data),
    .st_size  (size),
    .st_ofs   (addr_lo),
    .st_src   (r_q),
    .st_data  (w_st_data),
    .st_be    (w_st_be)
  );

  assign w_misal = md_misal(size, addr_lo[0], |addr_lo);

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_rd_nxt    = r_rd;
    w_wr_nxt    = r_wr;
    w_wdata_nxt = r_wdata;
    w_be_nxt    = r_be;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_sz_nxt    = r_sz;
    w_uns_nxt   = r_uns;
    w_ofs_nxt   = r_ofs;
`ifdef MDR_TIMEOUT_EN
    w_cnt_nxt   = r_cnt;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (rd_req || wr_req) begin
          if (w_misal) begin
            w_err_nxt = 1'b1;
          end else begin
            w_sz_nxt  = size;
            w_uns_nxt = unsigned_ld;
            w_ofs_nxt = addr_lo;
`ifdef MDR_TIMEOUT_EN
            w_cnt_nxt = '0;
`endif
            if (rd_req) begin
              w_state_nxt = ST_RD_WAIT;
              w_rd_nxt    = 1'b1;
            end else begin
              w_state_nxt = ST_WR_WAIT;
              w_wr_nxt    = 1'b1;
              w_wdata_nxt = w_st_data;
              w_be_nxt    = w_st_be;
            end
          end
        end else if (enable) begin
          w_q_nxt = bus_data;
        end
      end
      ST_RD_WAIT, ST_WR_WAIT: begin
        if (mem_ack) begin
          if (r_state == ST_RD_WAIT) w_q_nxt = w_ld_data;
          w_state_nxt = ST_IDLE;
          w_rd_nxt    = 1'b0;
          w_wr_nxt    = 1'b0;
          w_be_nxt    = '0;
          w_done_nxt  = 1'b1;
        end else begin
`ifdef MDR_TIMEOUT_EN
          if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            w_state_nxt = ST_IDLE;
            w_rd_nxt    = 1'b0;
            w_wr_nxt    = 1'b0;
            w_be_nxt    = '0;
            w_err_nxt   = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
`endif
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers, clr wins
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_wdata <= '0;
      r_be    <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_sz    <= SZ_BYTE;
      r_uns   <= 1'b0;
      r_ofs   <= '0;
`ifdef MDR_TIMEOUT_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_rd    <= w_rd_nxt;
      r_wr    <= w_wr_nxt;
      r_wdata <= w_wdata_nxt;
      r_be    <= w_be_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_sz    <= w_sz_nxt;
      r_uns   <= w_uns_nxt;
      r_ofs   <= w_ofs_nxt;
`ifdef MDR_TIMEOUT_EN
      r_cnt   <= w_cnt_nxt;
`endif
    end
  end

  assign Q         = r_q;
  assign mem_rd    = r_rd;
  assign mem_wr    = r_wr;
  assign mem_wdata = r_wdata;
  assign mem_be    = r_be;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_md_buffer.sv
// md_buffer testbench
// Directed plan plus random traffic against a transaction model.
module tb_md_buffer;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] bus_data = '0;
  logic        rd_req = 1'b0;
  logic        wr_req = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        unsigned_ld = 1'b0;
  logic [1:0]  addr_lo = 2'b00;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        mem_rd, mem_wr, busy, done, err;
  logic [31:0] mem_wdata, Q;
  logic [3:0]  mem_be;

  md_buffer #(.DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .clr(clr), .enable(enable), .bus_data(bus_data),
    .rd_req(rd_req), .wr_req(wr_req), .size(size),
    .unsigned_ld(unsigned_ld), .addr_lo(addr_lo),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .Q(Q), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // model: 0 idle, 1 read pending, 2 write pending
  int          m_mode = 0;
  int          m_nb = 1;
  int          m_ofs = 0;
  bit          m_uns = 1'b0;
  int          m_wait = 0;
  logic [31:0] e_q = '0;
  logic [31:0] e_wdata = '0;
  logic [3:0]  e_be = '0;
  logic        e_rd = 0, e_wr = 0, e_done = 0, e_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit misal(input int sz, input int ofs);
    return (sz == 3) || (sz == 1 && (ofs % 2) != 0) ||
           (sz == 2 && ofs != 0);
  endfunction

  task automatic model_edge();
    longint mask, lane, rep;
    int nb;
    e_done = 0;
    e_err  = 0;
    if (clr) begin
      m_mode = 0; e_q = '0; e_rd = 0; e_wr = 0;
      e_be = '0; e_wdata = '0;
    end else if (m_mode == 0) begin
      if (rd_req || wr_req) begin
        if (misal(int'(size), int'(addr_lo))) begin
          e_err = 1;
        end else begin
          m_nb   = 1 << size;
          m_ofs  = int'(addr_lo);
          m_uns  = unsigned_ld;
          m_wait = 0;
          if (rd_req) begin
            m_mode = 1; e_rd = 1;
          end else begin
            m_mode = 2; e_wr = 1;
            nb   = m_nb;
            mask = (64'd1 << (8 * nb)) - 1;
            rep  = 0;
            for (int k = 0; k < 4 / nb; k++)
              rep = rep | ((longint'(e_q) & mask) << (8 * nb * k));
            e_wdata = rep[31:0];
            e_be    = 4'(((1 << nb) - 1) << m_ofs);
          end
        end
      end else if (enable) begin
        e_q = bus_data;
      end
    end else begin
      if (mem_ack) begin
        if (m_mode == 1) begin
          mask = (64'd1 << (8 * m_nb)) - 1;
          lane = (longint'(mem_rdata) >> (8 * m_ofs)) & mask;
          if (!m_uns && m_nb < 4 && lane[8 * m_nb - 1])
            lane = lane | ~mask;
          e_q = lane[31:0];
        end
        m_mode = 0; e_rd = 0; e_wr = 0; e_be = '0; e_done = 1;
      end else begin
`ifdef MDR_TIMEOUT_EN
        m_wait++;
        if (m_wait == TO) begin
          m_mode = 0; e_rd = 0; e_wr = 0; e_be = '0; e_err = 1;
        end
`endif
      end
    end
  endtask

  task automatic compare();
    chk("Q", Q, e_q);
    chk("mem_rd", 32'(mem_rd), 32'(e_rd));
    chk("mem_wr", 32'(mem_wr), 32'(e_wr));
    chk("mem_be", 32'(mem_be), 32'(e_be));
    chk("busy", 32'(busy), 32'(m_mode != 0));
    chk("done", 32'(done), 32'(e_done));
    chk("err", 32'(err), 32'(e_err));
    if (e_wr) chk("mem_wdata", mem_wdata, e_wdata);
    chk("rd_wr_excl", 32'(mem_rd & mem_wr), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic idle_in();
    clr = 0; enable = 0; rd_req = 0; wr_req = 0; mem_ack = 0;
  endtask

  initial begin
    // reset and bus load
    clr = 1; step(); idle_in();
    chk("rst_Q", Q, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wdata", mem_wdata, 32'h0);
    enable = 1; bus_data = 32'hDEADBEEF; step(); idle_in();
    chk("bus_load", Q, 32'hDEADBEEF);

    // signed then unsigned byte load, ack in third wait cycle
    for (int u = 0; u < 2; u++) begin
      rd_req = 1; size = 2'b00; addr_lo = 2'd3; unsigned_ld = 1'(u);
      mem_rdata = 32'h80FF1234;
      step(); idle_in();
      size = 2'b10; addr_lo = 2'd0; unsigned_ld = 1'b0;
      chk("rd_issue", 32'(mem_rd), 32'd1);
      step(); step();
      chk("rd_wait_busy", 32'(busy), 32'd1);
      mem_ack = 1; step(); idle_in();
      chk("byte_load", Q, (u == 0) ? 32'hFFFFFF80 : 32'h00000080);
      chk("ld_done", 32'(done), 32'd1);
      step();
      chk("done_pulse", 32'(done), 32'd0);
    end

    // half store
    enable = 1; bus_data = 32'h0000ABCD; step(); idle_in();
    wr_req = 1; size = 2'b01; addr_lo = 2'd2; step(); idle_in();
    chk("st_be", 32'(mem_be), 32'b1100);
    chk("st_wdata", mem_wdata, 32'hABCDABCD);
    mem_ack = 1; step(); idle_in();
    chk("st_keepQ", Q, 32'h0000ABCD);

    // misaligned requests
    rd_req = 1; size = 2'b10; addr_lo = 2'd1; step(); idle_in();
    chk("mis_err", 32'(err), 32'd1);
    chk("mis_nord", 32'(mem_rd), 32'd0);
    wr_req = 1; size = 2'b11; addr_lo = 2'd0; step(); idle_in();
    chk("rsvd_err", 32'(err), 32'd1);
    chk("rsvd_keepQ", Q, 32'h0000ABCD);

    // clr in second wait cycle, late ack
    rd_req = 1; size = 2'b10; addr_lo = 2'd0; mem_rdata = 32'h12345678;
    step(); idle_in();
    step();
    clr = 1; step(); idle_in();
    mem_ack = 1; step(); idle_in();
    chk("abort_Q", Q, 32'h0);
    chk("abort_done", 32'(done), 32'd0);

    // no-ack wait
    rd_req = 1; size = 2'b00; addr_lo = 2'd0; step(); idle_in();
    for (int i = 0; i < TO - 1; i++) step();
    step();
`ifdef MDR_TIMEOUT_EN
    chk("to_err", 32'(err), 32'd1);
    chk("to_idle", 32'(busy), 32'd0);
`else
    chk("no_to_busy", 32'(busy), 32'd1);
    mem_ack = 1; step(); idle_in();
`endif

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      clr         = ($urandom_range(63) == 0);
      rd_req      = ($urandom_range(5) == 0);
      wr_req      = ($urandom_range(5) == 0);
      enable      = ($urandom_range(3) == 0);
      bus_data    = $urandom;
      size        = 2'($urandom_range(3));
      addr_lo     = 2'($urandom_range(3));
      unsigned_ld = 1'($urandom_range(1));
      mem_rdata   = $urandom;
      mem_ack     = ($urandom_range(2) == 0);
      step();
    end
    idle_in();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
